gamepad_reader: RTL

- Autonomous serial reader for two SNES-style gamepads sharing one latch/clock pair.
- Replaces software bit-banging of pad clock/latch through the pad WB register.
- Drives the existing gamepad_latch/gamepad_clk pad outputs and samples the two data inputs.
- Presents debounced-per-poll 16-bit button words to the WB adapter for the 0x3020 read path; can be triggered per video frame from the VDP frame_ended strobe.

---
 rtl/gamepad_reader_pkg.sv | 33 +++
 rtl/gamepad_reader_if.sv | 23 ++
 rtl/gamepad_reader_sync_2ff.sv | 21 ++
 rtl/gamepad_reader.sv | 122 ++++++++++++
 4 files changed

// File: rtl/gamepad_reader_pkg.sv
// rtl/gamepad_reader_pkg.sv - shared types and constants for the gamepad reader
package gamepad_reader_pkg;

    localparam int BUTTON_WORD_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LATCH  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_HIGH   = 3'd3,
        ST_LOW    = 3'd4,
        ST_FINISH = 3'd5
    } state_t;

    // SNES shift order: bit n of a button word is the nth bit clocked out
    localparam int BTN_B      = 0;
    localparam int BTN_Y      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;
    localparam int BTN_A      = 8;
    localparam int BTN_X      = 9;
    localparam int BTN_L      = 10;
    localparam int BTN_R      = 11;

    function automatic logic [BUTTON_WORD_W-1:0] button_mask(input int count);
        return BUTTON_WORD_W'((33'h1 << count) - 33'h1);
    endfunction

endpackage

// File: rtl/gamepad_reader_if.sv
// rtl/gamepad_reader_if.sv - host-side request/result bundle of the gamepad reader
interface gamepad_reader_if;
    import gamepad_reader_pkg::*;

    logic                     start;
    logic                     auto_en;
    logic                     frame_tick;
    logic [BUTTON_WORD_W-1:0] p1_buttons;
    logic [BUTTON_WORD_W-1:0] p2_buttons;
    logic                     busy;
    logic                     done;

    modport master (
        output start, auto_en, frame_tick,
        input  p1_buttons, p2_buttons, busy, done
    );

    modport slave (
        input  start, auto_en, frame_tick,
        output p1_buttons, p2_buttons, busy, done
    );

endinterface

// File: rtl/gamepad_reader_sync_2ff.sv
// rtl/gamepad_reader_sync_2ff.sv - 1-bit two-flop synchronizer
module gamepad_reader_sync_2ff (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/gamepad_reader.sv
// rtl/gamepad_reader.sv - autonomous dual SNES pad serial reader
module gamepad_reader
    import gamepad_reader_pkg::*;
#(
    parameter int HALF_PERIOD  = 4,
    parameter int BUTTON_COUNT = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    gamepad_reader_if.slave   host,
    input  logic              pad_data_p1,
    input  logic              pad_data_p2,
    output logic              pad_latch,
    output logic              pad_clk
);

    localparam int CW = $clog2(2 * HALF_PERIOD);
    localparam logic [CW-1:0] LATCH_LOAD = CW'(2 * HALF_PERIOD - 1);
    localparam logic [CW-1:0] HALF_LOAD  = CW'(HALF_PERIOD - 1);
    localparam logic [4:0]    LAST_K     = 5'(BUTTON_COUNT);

    state_t state, next_state;
    logic [CW-1:0]            phase;
    logic [4:0]               pulses;
    logic [4:0]               next_k;
    logic                     phase_done;
    logic                     req;
    logic                     data_p1, data_p2;
    logic                     sample_en;
    logic [3:0]               sample_idx;
    logic [BUTTON_WORD_W-1:0] sr_p1, sr_p2;

    gamepad_reader_sync_2ff u_sync_p1 (.clk(clk), .reset_n(reset_n), .d(pad_data_p1), .q(data_p1));
    gamepad_reader_sync_2ff u_sync_p2 (.clk(clk), .reset_n(reset_n), .d(pad_data_p2), .q(data_p2));

    assign req        = host.start | (host.auto_en & host.frame_tick);
    assign phase_done = (phase == '0);
    assign next_k     = pulses + 5'd1;

    always_comb begin
        next_state = state;
        sample_en  = 1'b0;
        sample_idx = 4'd0;
        case (state)
            ST_IDLE:   if (req) next_state = ST_LATCH;
            ST_LATCH:  if (phase_done) next_state = ST_SETTLE;
            ST_SETTLE: begin
                if (phase_done) begin
                    next_state = ST_HIGH;
                    sample_en  = 1'b1;
                end
            end
            ST_HIGH:   if (phase_done) next_state = ST_LOW;
            ST_LOW: begin
                // the sample after the final pulse lies past the last button and is dropped
                if (phase_done) begin
                    if (next_k == LAST_K) begin
                        next_state = ST_FINISH;
                    end else begin
                        next_state = ST_HIGH;
                        sample_en  = 1'b1;
                        sample_idx = next_k[3:0];
                    end
                end
            end
            ST_FINISH: next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // pad pins and host flags are registered from next_state so they line up with the state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase           <= '0;
            pulses          <= '0;
            sr_p1           <= '0;
            sr_p2           <= '0;
            host.p1_buttons <= '0;
            host.p2_buttons <= '0;
            host.busy       <= 1'b0;
            host.done       <= 1'b0;
            pad_latch       <= 1'b0;
            pad_clk         <= 1'b0;
        end else begin
            if (next_state != state) begin
                phase <= (next_state == ST_LATCH) ? LATCH_LOAD : HALF_LOAD;
            end else if (!phase_done) begin
                phase <= phase - 1'b1;
            end

            if (state == ST_IDLE) begin
                pulses <= '0;
            end else if (state == ST_LOW && phase_done) begin
                pulses <= next_k;
            end

            if (sample_en) begin
                sr_p1[sample_idx] <= ~data_p1;
                sr_p2[sample_idx] <= ~data_p2;
            end

            if (next_state == ST_FINISH) begin
                host.p1_buttons <= sr_p1 & button_mask(BUTTON_COUNT);
                host.p2_buttons <= sr_p2 & button_mask(BUTTON_COUNT);
            end

            host.done <= (next_state == ST_FINISH);
            host.busy <= (next_state != ST_IDLE);
            pad_latch <= (next_state == ST_LATCH);
            pad_clk   <= (next_state == ST_HIGH);
        end
    end

endmodule
